// File: rtl/i2s_input_if.sv
// Audio ADC I2S link: raw codec pins in, deserialised L/R pair out.
interface i2s_input_if #(
  parameter int WIDTH = 16
);
  logic             AUD_BCLK;
  logic             AUD_ADCLRCK;
  logic             AUD_ADCDAT;
  logic [WIDTH-1:0] sample_left;
  logic [WIDTH-1:0] sample_right;
  logic             sample_strobe;
  logic             frame_error;

  modport master (
    output AUD_BCLK, AUD_ADCLRCK, AUD_ADCDAT,
    input  sample_left, sample_right, sample_strobe, frame_error
  );

  modport slave (
    input  AUD_BCLK, AUD_ADCLRCK, AUD_ADCDAT,
    output sample_left, sample_right, sample_strobe, frame_error
  );
endinterface

// File: rtl/i2s_input.sv
// I2S slave receiver: oversamples BCLK/LRCLK/DAT on the system clock and
// emits one MSB-aligned left/right sample pair per frame with a 1-cycle strobe.
module i2s_input #(
  parameter int WIDTH     = 16,
  parameter int I2S_DELAY = 0
) (
  input  logic       clock,
  input  logic       reset,
  i2s_input_if.slave bus
);
  typedef enum logic [1:0] {HUNT, LEFT, RIGHT} state_t;

  localparam logic [5:0] LIM = 6'(WIDTH + I2S_DELAY);

  state_t           r_state;
  logic [2:0]       r_bclk_s;
  logic [1:0]       r_lr_s;
  logic [1:0]       r_dat_s;
  logic             r_prev_lr;
  logic [4:0]       r_bit_cnt;
  logic [WIDTH-1:0] r_shift;
  logic [WIDTH-1:0] r_hold_left;
  logic             r_short_l;
  logic [WIDTH-1:0] r_sample_left;
  logic [WIDTH-1:0] r_sample_right;
  logic             r_strobe;
  logic             r_frame_error;

  logic             w_rise;
  logic             w_lr;
  logic             w_dat;
  logic             w_edge;
  logic             w_fall;
  logic             w_lr_rise;
  logic             w_short;
  logic [WIDTH-1:0] w_mask;

  assign w_rise    = r_bclk_s[1] & ~r_bclk_s[2];
  assign w_lr      = r_lr_s[1];
  assign w_dat     = r_dat_s[1];
  assign w_edge    = w_lr ^ r_prev_lr;
  assign w_fall    = ~w_lr & r_prev_lr;
  assign w_lr_rise = w_lr & ~r_prev_lr;
  assign w_short   = {1'b0, r_bit_cnt} < LIM;

  // One-hot write position for bit k = r_bit_cnt; empty outside the sample window.
  always_comb begin
    w_mask = '0;
    for (int i = 0; i < WIDTH; i++)
      w_mask[i] = (r_bit_cnt == 5'(WIDTH - 1 + I2S_DELAY - i));
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state        <= HUNT;
      r_bclk_s       <= '0;
      r_lr_s         <= '0;
      r_dat_s        <= '0;
      r_prev_lr      <= 1'b1;
      r_bit_cnt      <= '0;
      r_shift        <= '0;
      r_hold_left    <= '0;
      r_short_l      <= 1'b0;
      r_sample_left  <= '0;
      r_sample_right <= '0;
      r_strobe       <= 1'b0;
      r_frame_error  <= 1'b0;
    end else begin
      r_bclk_s <= {r_bclk_s[1:0], bus.AUD_BCLK};
      r_lr_s   <= {r_lr_s[0], bus.AUD_ADCLRCK};
      r_dat_s  <= {r_dat_s[0], bus.AUD_ADCDAT};
      r_strobe <= 1'b0;
      if (w_rise) begin
        r_prev_lr <= w_lr;
        // The rise that sees an LRCLK edge already carries bit 0 of the new half.
        if (w_edge) begin
          r_bit_cnt <= 5'd1;
          r_shift   <= '0;
          if (I2S_DELAY == 0) r_shift[WIDTH-1] <= w_dat;
        end else begin
          if (r_bit_cnt != 5'd31) r_bit_cnt <= r_bit_cnt + 5'd1;
          r_shift <= (r_shift & ~w_mask) | (w_mask & {WIDTH{w_dat}});
        end
        case (r_state)
          HUNT: if (w_fall) r_state <= LEFT;
          LEFT: if (w_lr_rise) begin
            r_hold_left <= r_shift;
            r_short_l   <= w_short;
            r_state     <= RIGHT;
          end
          RIGHT: if (w_fall) begin
            r_sample_left  <= r_hold_left;
            r_sample_right <= r_shift;
            r_frame_error  <= r_short_l | w_short;
            r_strobe       <= 1'b1;
            r_state        <= LEFT;
          end
          default: r_state <= HUNT;
        endcase
      end
    end
  end

  assign bus.sample_left   = r_sample_left;
  assign bus.sample_right  = r_sample_right;
  assign bus.sample_strobe = r_strobe;
  assign bus.frame_error   = r_frame_error;
endmodule

// File: tb/tb_i2s_input.sv
// Bench for i2s_input: a left-justified and a Philips-delay receiver share one
// serial stream; strobed pairs are logged and matched against an expected queue.
module tb_i2s_input;
  typedef struct {
    logic [15:0] l;
    logic [15:0] r;
    logic        e;
  } exp_t;

  logic clock = 1'b0;
  logic reset = 1'b1;
  logic bclk  = 1'b0;
  logic lrck  = 1'b1;
  logic dat   = 1'b0;

  i2s_input_if #(.WIDTH(16)) b0 ();
  i2s_input_if #(.WIDTH(16)) b1 ();

  assign b0.AUD_BCLK    = bclk;
  assign b0.AUD_ADCLRCK = lrck;
  assign b0.AUD_ADCDAT  = dat;
  assign b1.AUD_BCLK    = bclk;
  assign b1.AUD_ADCLRCK = lrck;
  assign b1.AUD_ADCDAT  = dat;

  i2s_input #(.WIDTH(16), .I2S_DELAY(0)) dut0 (.clock(clock), .reset(reset), .bus(b0.slave));
  i2s_input #(.WIDTH(16), .I2S_DELAY(1)) dut1 (.clock(clock), .reset(reset), .bus(b1.slave));

  always #4 clock = ~clock;

  // Strobe log, written only here; the tests read it through rd0/rd1.
  logic [15:0] o0_l [256];
  logic [15:0] o0_r [256];
  logic        o0_e [256];
  int          o0_t [256];
  logic [15:0] o1_l [256];
  logic [15:0] o1_r [256];
  logic        o1_e [256];
  int o0_n = 0, o1_n = 0, o0_dbl = 0, cyc = 0;
  logic prev_s0 = 1'b0;

  always @(posedge clock) cyc <= cyc + 1;

  always @(negedge clock) begin
    prev_s0 <= b0.sample_strobe;
    if (b0.sample_strobe) begin
      if (prev_s0) o0_dbl <= o0_dbl + 1;
      o0_l[o0_n[7:0]] <= b0.sample_left;
      o0_r[o0_n[7:0]] <= b0.sample_right;
      o0_e[o0_n[7:0]] <= b0.frame_error;
      o0_t[o0_n[7:0]] <= cyc;
      o0_n <= o0_n + 1;
    end
    if (b1.sample_strobe) begin
      o1_l[o1_n[7:0]] <= b1.sample_left;
      o1_r[o1_n[7:0]] <= b1.sample_right;
      o1_e[o1_n[7:0]] <= b1.frame_error;
      o1_n <= o1_n + 1;
    end
  end

  exp_t q0[$];
  exp_t q1[$];
  int rd0 = 0, rd1 = 0;
  int n_pass = 0, n_checks = 0;

  task automatic bit_out(input logic lr, input logic d, input int hp);
    lrck = lr;
    dat  = d;
    bclk = 1'b0;
    repeat (hp) @(negedge clock);
    bclk = 1'b1;
    repeat (hp) @(negedge clock);
  endtask

  task automatic send_half(input logic lr, input logic [15:0] v, input int nbits,
                           input int dly, input int hp);
    for (int i = 0; i < nbits; i++) begin
      int   j;
      logic d;
      j = i - dly;
      if (j < 0)       d = ~v[15];
      else if (j < 16) d = v[15-j];
      else             d = 1'($urandom_range(1));
      bit_out(lr, d, hp);
    end
  endtask

  task automatic push0(input logic [15:0] l, input logic [15:0] r, input logic e);
    exp_t x;
    x.l = l; x.r = r; x.e = e;
    q0.push_back(x);
  endtask

  task automatic do_reset();
    bclk = 1'b0;
    @(negedge clock);
    reset = 1'b1;
    repeat (3) @(negedge clock);
    reset = 1'b0;
    repeat (2) @(negedge clock);
    q0.delete(); q1.delete();
    rd0 = o0_n; rd1 = o1_n;
  endtask

  task automatic test_reset();
    lrck = 1'b1; dat = 1'b0; bclk = 1'b0;
    repeat (4) @(negedge clock);
    reset = 1'b0;
    repeat (4) @(negedge clock);
    n_checks++;
    if ({b0.sample_left, b0.sample_right, b0.sample_strobe, b0.frame_error} !== 34'h0)
      $display("FAIL reset dut0: got %h/%h s=%b e=%b required 0", b0.sample_left,
               b0.sample_right, b0.sample_strobe, b0.frame_error);
    else n_pass++;
    n_checks++;
    if ({b1.sample_left, b1.sample_right, b1.sample_strobe, b1.frame_error} !== 34'h0)
      $display("FAIL reset dut1: got %h/%h s=%b e=%b required 0", b1.sample_left,
               b1.sample_right, b1.sample_strobe, b1.frame_error);
    else n_pass++;
  endtask

  task automatic test_lead_in();
    exp_t e;
    do_reset();
    // Right-channel lead-in: HUNT must skip it without locking or strobing.
    send_half(1'b1, 16'h0, 16, 0, 20);
    push0(16'hA55A, 16'h1234, 1'b0);
    send_half(1'b0, 16'hA55A, 32, 0, 20);
    send_half(1'b1, 16'h1234, 32, 0, 20);
    bit_out(1'b0, 1'b0, 20);
    repeat (8) @(negedge clock);
    n_checks++;
    if (o0_n - rd0 !== q0.size())
      $display("FAIL lead_in count: got %0d strobes required %0d", o0_n - rd0, q0.size());
    else n_pass++;
    while (rd0 < o0_n && q0.size() > 0) begin
      e = q0.pop_front();
      n_checks++;
      if ({o0_l[rd0[7:0]], o0_r[rd0[7:0]], o0_e[rd0[7:0]]} !== {e.l, e.r, e.e})
        $display("FAIL lead_in pair: got %h/%h e=%b required %h/%h e=%b",
                 o0_l[rd0[7:0]], o0_r[rd0[7:0]], o0_e[rd0[7:0]], e.l, e.r, e.e);
      else n_pass++;
      rd0++;
    end
  endtask

  task automatic test_stream();
    exp_t e;
    int   first, bad, dbl0;
    do_reset();
    first = o0_n;
    dbl0  = o0_dbl;
    for (int n = 0; n < 48; n++) begin
      if (n < 47) push0(16'(n), ~16'(n), 1'b0);
      send_half(1'b0, 16'(n), 32, 0, 5);
      send_half(1'b1, ~16'(n), 32, 0, 5);
    end
    repeat (8) @(negedge clock);
    n_checks++;
    if (o0_n - rd0 !== q0.size())
      $display("FAIL stream count: got %0d strobes required %0d", o0_n - rd0, q0.size());
    else n_pass++;
    while (rd0 < o0_n && q0.size() > 0) begin
      e = q0.pop_front();
      n_checks++;
      if ({o0_l[rd0[7:0]], o0_r[rd0[7:0]], o0_e[rd0[7:0]]} !== {e.l, e.r, e.e})
        $display("FAIL stream pair %0d: got %h/%h e=%b required %h/%h e=%b", rd0 - first,
                 o0_l[rd0[7:0]], o0_r[rd0[7:0]], o0_e[rd0[7:0]], e.l, e.r, e.e);
      else n_pass++;
      rd0++;
    end
    bad = 0;
    for (int i = first + 1; i < o0_n; i++)
      if (o0_t[i[7:0]] - o0_t[i-1] != 640) bad++;
    n_checks++;
    if (bad !== 0) $display("FAIL stream spacing: got %0d bad gaps required 0", bad);
    else n_pass++;
    n_checks++;
    if (o0_dbl - dbl0 !== 0)
      $display("FAIL stream strobe width: got %0d multi-cycle strobes required 0", o0_dbl - dbl0);
    else n_pass++;
  endtask

  task automatic test_delay();
    exp_t e;
    do_reset();
    e.l = 16'h8001; e.r = 16'h7FFE; e.e = 1'b0;
    q1.push_back(e);
    send_half(1'b0, 16'h8001, 32, 1, 5);
    send_half(1'b1, 16'h7FFE, 32, 1, 5);
    bit_out(1'b0, 1'b0, 5);
    repeat (8) @(negedge clock);
    n_checks++;
    if (o1_n - rd1 !== q1.size())
      $display("FAIL delay count: got %0d strobes required %0d", o1_n - rd1, q1.size());
    else n_pass++;
    while (rd1 < o1_n && q1.size() > 0) begin
      e = q1.pop_front();
      n_checks++;
      if ({o1_l[rd1[7:0]], o1_r[rd1[7:0]], o1_e[rd1[7:0]]} !== {e.l, e.r, e.e})
        $display("FAIL delay pair: got %h/%h e=%b required %h/%h e=%b",
                 o1_l[rd1[7:0]], o1_r[rd1[7:0]], o1_e[rd1[7:0]], e.l, e.r, e.e);
      else n_pass++;
      rd1++;
    end
  endtask

  task automatic test_short();
    exp_t e;
    do_reset();
    push0(16'hFFF0, 16'h0F0F, 1'b1);
    send_half(1'b0, 16'hFFF0, 12, 0, 5);
    send_half(1'b1, 16'h0F0F, 32, 0, 5);
    push0(16'h1357, 16'h2468, 1'b0);
    send_half(1'b0, 16'h1357, 32, 0, 5);
    send_half(1'b1, 16'h2468, 32, 0, 5);
    bit_out(1'b0, 1'b0, 5);
    repeat (8) @(negedge clock);
    n_checks++;
    if (o0_n - rd0 !== q0.size())
      $display("FAIL short count: got %0d strobes required %0d", o0_n - rd0, q0.size());
    else n_pass++;
    while (rd0 < o0_n && q0.size() > 0) begin
      e = q0.pop_front();
      n_checks++;
      if ({o0_l[rd0[7:0]], o0_r[rd0[7:0]], o0_e[rd0[7:0]]} !== {e.l, e.r, e.e})
        $display("FAIL short pair: got %h/%h e=%b required %h/%h e=%b",
                 o0_l[rd0[7:0]], o0_r[rd0[7:0]], o0_e[rd0[7:0]], e.l, e.r, e.e);
      else n_pass++;
      rd0++;
    end
  endtask

  task automatic test_midreset();
    exp_t e;
    do_reset();
    push0(16'hAAAA, 16'h5555, 1'b0);
    send_half(1'b0, 16'hAAAA, 32, 0, 5);
    send_half(1'b1, 16'h5555, 32, 0, 5);
    send_half(1'b0, 16'h3C3C, 32, 0, 5);
    send_half(1'b1, 16'hC3C3, 10, 0, 5);
    bclk = 1'b0;
    repeat (3) @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    n_checks++;
    if ({b0.sample_left, b0.sample_right, b0.sample_strobe, b0.frame_error} !== 34'h0)
      $display("FAIL midreset outputs: got %h/%h s=%b e=%b required 0", b0.sample_left,
               b0.sample_right, b0.sample_strobe, b0.frame_error);
    else n_pass++;
    send_half(1'b1, 16'hC3C3, 22, 0, 5);
    push0(16'h0F1E, 16'hE1F0, 1'b0);
    send_half(1'b0, 16'h0F1E, 32, 0, 5);
    send_half(1'b1, 16'hE1F0, 32, 0, 5);
    bit_out(1'b0, 1'b0, 5);
    repeat (8) @(negedge clock);
    n_checks++;
    if (o0_n - rd0 !== q0.size())
      $display("FAIL midreset count: got %0d strobes required %0d", o0_n - rd0, q0.size());
    else n_pass++;
    while (rd0 < o0_n && q0.size() > 0) begin
      e = q0.pop_front();
      n_checks++;
      if ({o0_l[rd0[7:0]], o0_r[rd0[7:0]], o0_e[rd0[7:0]]} !== {e.l, e.r, e.e})
        $display("FAIL midreset pair: got %h/%h e=%b required %h/%h e=%b",
                 o0_l[rd0[7:0]], o0_r[rd0[7:0]], o0_e[rd0[7:0]], e.l, e.r, e.e);
      else n_pass++;
      rd0++;
    end
  endtask

  task automatic test_stuck();
    exp_t e;
    do_reset();
    push0(16'h1111, 16'h2222, 1'b0);
    send_half(1'b0, 16'h1111, 32, 0, 5);
    send_half(1'b1, 16'h2222, 32, 0, 5);
    bit_out(1'b0, 1'b0, 5);
    repeat (200) bit_out(1'b0, 1'b0, 5);
    n_checks++;
    if ({o0_n - rd0, b0.sample_left, b0.sample_right, b0.frame_error} !== {32'd1, 16'h1111, 16'h2222, 1'b0})
      $display("FAIL stuck hold: got %0d strobes %h/%h e=%b required 1 1111/2222 e=0",
               o0_n - rd0, b0.sample_left, b0.sample_right, b0.frame_error);
    else n_pass++;
    // Left half spanning the stuck run was all zeros and saturated, so not short.
    push0(16'h0000, 16'h4321, 1'b0);
    send_half(1'b1, 16'h4321, 32, 0, 5);
    push0(16'hABCD, 16'hDCBA, 1'b0);
    send_half(1'b0, 16'hABCD, 32, 0, 5);
    send_half(1'b1, 16'hDCBA, 32, 0, 5);
    bit_out(1'b0, 1'b0, 5);
    repeat (8) @(negedge clock);
    n_checks++;
    if (o0_n - rd0 !== q0.size())
      $display("FAIL stuck count: got %0d strobes required %0d", o0_n - rd0, q0.size());
    else n_pass++;
    while (rd0 < o0_n && q0.size() > 0) begin
      e = q0.pop_front();
      n_checks++;
      if ({o0_l[rd0[7:0]], o0_r[rd0[7:0]], o0_e[rd0[7:0]]} !== {e.l, e.r, e.e})
        $display("FAIL stuck pair: got %h/%h e=%b required %h/%h e=%b",
                 o0_l[rd0[7:0]], o0_r[rd0[7:0]], o0_e[rd0[7:0]], e.l, e.r, e.e);
      else n_pass++;
      rd0++;
    end
  endtask

  initial begin
    test_reset();
    test_lead_in();
    test_stream();
    test_delay();
    test_short();
    test_midreset();
    test_stuck();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
